top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 111 +++++++++++
 tb/tb_top.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// 39-input majority voter: a full-adder compressor stage feeds a binary adder tree.
// The registered output is 1 when at least 20 of the 39 votes are set.
module top (
    input  logic clk,
    input  logic rst_n,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic x5,
    input  logic x6,
    input  logic x7,
    input  logic x8,
    input  logic x9,
    input  logic x10,
    input  logic x11,
    input  logic x12,
    input  logic x13,
    input  logic x14,
    input  logic x15,
    input  logic x16,
    input  logic x17,
    input  logic x18,
    input  logic x19,
    input  logic x20,
    input  logic x21,
    input  logic x22,
    input  logic x23,
    input  logic x24,
    input  logic x25,
    input  logic x26,
    input  logic x27,
    input  logic x28,
    input  logic x29,
    input  logic x30,
    input  logic x31,
    input  logic x32,
    input  logic x33,
    input  logic x34,
    input  logic x35,
    input  logic x36,
    input  logic x37,
    input  logic x38,
    output logic y0
);

    localparam int unsigned N_IN   = 39;
    localparam int unsigned THRESH = 20;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned N_FA   = N_IN / 3;

    logic [N_IN-1:0] x_c;
    assign x_c = {x38, x37, x36, x35, x34, x33, x32, x31, x30, x29,
                  x28, x27, x26, x25, x24, x23, x22, x21, x20, x19,
                  x18, x17, x16, x15, x14, x13, x12, x11, x10, x9,
                  x8,  x7,  x6,  x5,  x4,  x3,  x2,  x1,  x0};

    // Each full adder turns a triple of votes into a 2-bit count (carry, sum).
    logic [1:0] cnt1_c [N_FA];
    always_comb begin
        for (int i = 0; i < int'(N_FA); i++) begin
            cnt1_c[i][0] = x_c[3*i] ^ x_c[3*i+1] ^ x_c[3*i+2];
            cnt1_c[i][1] = (x_c[3*i] & x_c[3*i+1]) |
                           (x_c[3*i] & x_c[3*i+2]) |
                           (x_c[3*i+1] & x_c[3*i+2]);
        end
    end

    // Adder tree: 13 x 2b -> 7 x 3b -> 4 x 4b -> 2 x 5b -> 1 x 6b (max 39).
    logic [2:0]       cnt2_c [7];
    logic [3:0]       cnt3_c [4];
    logic [4:0]       cnt4_c [2];
    logic [CNT_W-1:0] pop_c;
    logic             maj_c;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            cnt2_c[i] = 3'(cnt1_c[2*i]) + 3'(cnt1_c[2*i+1]);
        end
        cnt2_c[6] = 3'(cnt1_c[12]);

        for (int i = 0; i < 3; i++) begin
            cnt3_c[i] = 4'(cnt2_c[2*i]) + 4'(cnt2_c[2*i+1]);
        end
        cnt3_c[3] = 4'(cnt2_c[6]);

        for (int i = 0; i < 2; i++) begin
            cnt4_c[i] = 5'(cnt3_c[2*i]) + 5'(cnt3_c[2*i+1]);
        end

        pop_c = CNT_W'(cnt4_c[0]) + CNT_W'(cnt4_c[1]);
        maj_c = (pop_c >= CNT_W'(THRESH));
    end

    logic y0_q;
    logic y0_d;

    assign y0_d = maj_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y0_q <= 1'b0;
        end else begin
            y0_q <= y0_d;
        end
    end

    assign y0 = y0_q;

endmodule

// File: tb/tb_top.sv
// Randomized self-checking bench for the 39-input majority voter with a bit-counting model.
module tb_top;

    logic        clk;
    logic        rst_n;
    logic [38:0] x;
    logic        y0;

    int n_cmp;
    int n_err;

    top dut (
        .clk(clk), .rst_n(rst_n),
        .x0(x[0]),   .x1(x[1]),   .x2(x[2]),   .x3(x[3]),   .x4(x[4]),
        .x5(x[5]),   .x6(x[6]),   .x7(x[7]),   .x8(x[8]),   .x9(x[9]),
        .x10(x[10]), .x11(x[11]), .x12(x[12]), .x13(x[13]), .x14(x[14]),
        .x15(x[15]), .x16(x[16]), .x17(x[17]), .x18(x[18]), .x19(x[19]),
        .x20(x[20]), .x21(x[21]), .x22(x[22]), .x23(x[23]), .x24(x[24]),
        .x25(x[25]), .x26(x[26]), .x27(x[27]), .x28(x[28]), .x29(x[29]),
        .x30(x[30]), .x31(x[31]), .x32(x[32]), .x33(x[33]), .x34(x[34]),
        .x35(x[35]), .x36(x[36]), .x37(x[37]), .x38(x[38]),
        .y0(y0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count the set votes and compare against the strict majority of 39.
    function automatic logic ref_maj(input logic [38:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 39; i++) n += int'(v[i]);
        return (n >= 20);
    endfunction

    function automatic logic [38:0] vec_with_ones(input int k);
        logic [38:0] v;
        int n;
        int idx;
        v = '0;
        n = 0;
        while (n < k) begin
            idx = int'($urandom_range(38, 0));
            if (!v[idx]) begin
                v[idx] = 1'b1;
                n++;
            end
        end
        return v;
    endfunction

    // Drive at the falling edge, then advance past the next rising edge.
    task automatic apply(input logic [38:0] v, input logic r);
        @(negedge clk);
        x     = v;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply('1, 1'b0);
        apply('1, 1'b0);
        n_cmp++;
        if (y0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_all_ones: y0=%b expected 0", y0);
        end
        apply('1, 1'b1);
        n_cmp++;
        if (y0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: y0=%b expected 1", y0);
        end
    endtask

    task automatic test_extremes();
        logic [38:0] v [4];
        logic        e [4];
        v[0] = 39'h0;           e[0] = 1'b0;
        v[1] = 39'h7F_FFFF_FFFF; e[1] = 1'b1;
        v[2] = 39'h0;           e[2] = 1'b0;
        v[3] = 39'h7F_FFFF_FFFF; e[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(v[i], 1'b1);
            n_cmp++;
            if (y0 !== e[i]) begin
                n_err++;
                $display("FAIL extremes[%0d]: x=%h y0=%b expected %b", i, v[i], y0, e[i]);
            end
        end
    endtask

    task automatic test_threshold();
        logic [38:0] v [4];
        logic        e [4];
        v[0] = 39'h00_000F_FFFF; e[0] = 1'b1;
        v[1] = 39'h00_0007_FFFF; e[1] = 1'b0;
        v[2] = 39'h7F_FFF8_0000; e[2] = 1'b1;
        v[3] = 39'h7F_FFF0_0000; e[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(v[i], 1'b1);
            n_cmp++;
            if (y0 !== e[i]) begin
                n_err++;
                $display("FAIL threshold[%0d]: x=%h y0=%b expected %b", i, v[i], y0, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          pc [4];
        logic        e  [4];
        logic [38:0] v;
        pc[0] = 19; pc[1] = 20; pc[2] = 19; pc[3] = 20;
        e[0] = 1'b0; e[1] = 1'b1; e[2] = 1'b0; e[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = vec_with_ones(pc[i]);
            apply(v, 1'b1);
            n_cmp++;
            if (y0 !== e[i]) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: x=%h y0=%b expected %b", i, v, y0, e[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [38:0] v;
        v = vec_with_ones(25);
        apply(v, 1'b1);
        x = ~v;
        #2;
        n_cmp++;
        if (y0 !== 1'b1) begin
            n_err++;
            $display("FAIL hold_between_edges: y0=%b expected 1", y0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (y0 !== 1'b0) begin
            n_err++;
            $display("FAIL hold_next_edge: y0=%b expected 0", y0);
        end
    endtask

    task automatic test_sync_reset();
        logic [38:0] v;
        v = vec_with_ones(30);
        apply(v, 1'b1);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (y0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_not_async: y0=%b expected 1", y0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (y0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_glitch_ignored: y0=%b expected 1", y0);
        end
    endtask

    task automatic test_midstream_reset();
        logic [38:0] v;
        logic        e [5];
        logic        r [5];
        r[0] = 1'b1; r[1] = 1'b1; r[2] = 1'b0; r[3] = 1'b1; r[4] = 1'b1;
        e[0] = 1'b1; e[1] = 1'b1; e[2] = 1'b0; e[3] = 1'b1; e[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v = vec_with_ones(30);
            apply(v, r[i]);
            n_cmp++;
            if (y0 !== e[i]) begin
                n_err++;
                $display("FAIL midstream_reset[%0d]: y0=%b expected %b", i, y0, e[i]);
            end
        end
    endtask

    task automatic test_walking();
        logic [38:0] v;
        for (int i = 0; i < 39; i++) begin
            v = 39'h1 << i;
            apply(v, 1'b1);
            n_cmp++;
            if (y0 !== ref_maj(v)) begin
                n_err++;
                $display("FAIL walking_one[%0d]: y0=%b expected %b", i, y0, ref_maj(v));
            end
            apply(~v, 1'b1);
            n_cmp++;
            if (y0 !== ref_maj(~v)) begin
                n_err++;
                $display("FAIL walking_zero[%0d]: y0=%b expected %b", i, y0, ref_maj(~v));
            end
        end
    endtask

    task automatic test_random();
        logic [38:0] v;
        logic        e;
        for (int i = 0; i < 20000; i++) begin
            if (i % 4 == 0) v = vec_with_ones(int'($urandom_range(24, 15)));
            else            v = 39'({$urandom(), $urandom()});
            apply(v, 1'b1);
            e = ref_maj(v);
            n_cmp++;
            if (y0 !== e) begin
                n_err++;
                $display("FAIL random[%0d]: x=%h y0=%b expected %b", i, v, y0, e);
            end
            if (i % 16 == 0) begin
                apply(~v, 1'b1);
                n_cmp++;
                if (y0 !== ~e) begin
                    n_err++;
                    $display("FAIL self_dual[%0d]: x=%h y0=%b expected %b", i, ~v, y0, ~e);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        x     = '0;
        test_reset();
        test_extremes();
        test_threshold();
        test_back_to_back();
        test_hold();
        test_sync_reset();
        test_midstream_reset();
        test_walking();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
